// File: rtl/stopwatch_bcd_pkg.sv
// stopwatch_pkg
// Shared types and constants for the BCD stopwatch.
//   sw_state_t : control FSM state encoding (IDLE, RUN, PAUSE, DONE)
//   bcd_t      : one 4-bit BCD digit
//   *_MOD      : modulus of each display digit
//   bcd_top()  : last legal value of a digit with a given modulus
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam int HUND_MOD = 10;
    localparam int SEC0_MOD = 10;
    localparam int SEC1_MOD = 6;
    localparam int MIN_MOD  = 10;

    function automatic bcd_t bcd_top(input int modulus);
        return bcd_t'(modulus - 1);
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// bcd_digit
// One decade of the stopwatch display counter.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset, q -> 0
//   clr   : synchronous clear, q -> 0
//   inc   : advance by one this cycle
//   q     : current digit value, always in 0..MOD-1
//   carry : combinational, high when this increment wraps the digit
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    logic at_top;

    assign at_top = (q == bcd_top(MOD));
    assign carry  = inc && at_top;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc) begin
            q <= at_top ? '0 : q + bcd_t'(1);
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd
// M:SS.hh stopwatch driven by an upstream 1 ms tick, with start/pause/clear
// control and either wrap-around or saturation at 9:59.99.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   tick       : single-cycle 1 ms strobe
//   start_stop : single-cycle start / pause / resume pulse
//   clear      : single-cycle pulse, zero the time and return to IDLE
//   timer_en   : enable for the upstream millisecond timer (high in RUN)
//   running    : high in RUN
//   done       : high in DONE (saturated at 9:59.99)
//   ovf        : one-cycle pulse when an increment passes 9:59.99
//   d_hund0..d_min : BCD display digits
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_HUND = 10,
    parameter bit WRAP           = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic start_stop,
    input  logic clear,
    output logic timer_en,
    output logic running,
    output logic done,
    output logic ovf,
    output bcd_t d_hund0,
    output bcd_t d_hund1,
    output bcd_t d_sec0,
    output bcd_t d_sec1,
    output bcd_t d_min
);

    localparam logic [9:0] PRESC_LAST = 10'(TICKS_PER_HUND - 1);

    sw_state_t  state;
    sw_state_t  state_nx;
    logic [9:0] presc;

    logic counted;
    logic hund_fire;
    logic at_max;
    logic ovf_evt;
    logic hund_inc;
    logic c_hund0;
    logic c_hund1;
    logic c_sec0;
    logic c_sec1;
    logic c_min;

    // A tick only counts while running; a simultaneous clear wins over it.
    assign counted   = tick && (state == RUN) && !clear;
    assign hund_fire = counted && (presc == PRESC_LAST);

    assign at_max = (d_min   == bcd_top(MIN_MOD))  &&
                    (d_sec1  == bcd_top(SEC1_MOD)) &&
                    (d_sec0  == bcd_top(SEC0_MOD)) &&
                    (d_hund1 == bcd_top(HUND_MOD)) &&
                    (d_hund0 == bcd_top(HUND_MOD));

    // In saturating mode the cascade is never advanced past 9:59.99, so the
    // minute carry cannot fire there and the overflow is detected up front.
    assign hund_inc = hund_fire && (WRAP || !at_max);
    assign ovf_evt  = WRAP ? c_min : (hund_fire && at_max);

    // Next-state logic: clear beats start_stop; a saturating overflow forces
    // DONE even if start_stop arrived in the same cycle.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            if (start_stop) begin
                case (state)
                    IDLE:    state_nx = RUN;
                    RUN:     state_nx = PAUSE;
                    PAUSE:   state_nx = RUN;
                    default: state_nx = state;
                endcase
            end
            if (!WRAP && ovf_evt) begin
                state_nx = DONE;
            end
        end
    end

    // State, prescaler and status flags. Flags are decoded from the next
    // state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            timer_en <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nx;
            timer_en <= (state_nx == RUN);
            running  <= (state_nx == RUN);
            done     <= (state_nx == DONE);
            ovf      <= ovf_evt;
            if (clear) begin
                presc <= '0;
            end else if (counted) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 10'd1;
            end
        end
    end

    bcd_digit #(.MOD(HUND_MOD)) u_hund0 (
        .clk(clk), .rst(rst), .clr(clear), .inc(hund_inc), .q(d_hund0), .carry(c_hund0)
    );
    bcd_digit #(.MOD(HUND_MOD)) u_hund1 (
        .clk(clk), .rst(rst), .clr(clear), .inc(c_hund0), .q(d_hund1), .carry(c_hund1)
    );
    bcd_digit #(.MOD(SEC0_MOD)) u_sec0 (
        .clk(clk), .rst(rst), .clr(clear), .inc(c_hund1), .q(d_sec0), .carry(c_sec0)
    );
    bcd_digit #(.MOD(SEC1_MOD)) u_sec1 (
        .clk(clk), .rst(rst), .clr(clear), .inc(c_sec0), .q(d_sec1), .carry(c_sec1)
    );
    bcd_digit #(.MOD(MIN_MOD)) u_min (
        .clk(clk), .rst(rst), .clr(clear), .inc(c_sec1), .q(d_min), .carry(c_min)
    );

endmodule
